// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the MEM-stage data memory access path:
// access sizes, exception codes and the access controller state type.
package cpu_mem_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b10;
  localparam logic [1:0] SIZE_BYTE = 2'b01;
  localparam logic [1:0] SIZE_RSV  = 2'b11;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;
  localparam logic [4:0] EXC_RI   = 5'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Reserved size wins over misalignment; otherwise direction picks AdES/AdEL.
  function automatic logic [4:0] addr_exc_code(input logic [1:0] size, input logic we);
    logic [4:0] code;
    if (size == SIZE_RSV) begin
      code = EXC_RI;
    end else if (we) begin
      code = EXC_ADES;
    end else begin
      code = EXC_ADEL;
    end
    return code;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the data bus: byte enables and replicated store data
// on the way out, lane selection and sign/zero extension on the way back.
module mem_lane_align
  import cpu_mem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  input  logic        sign_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byteLane;
  logic [15:0] halfLane;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    rdata_o    = rdata_i;
    misalign_o = 1'b0;
    byteLane   = rdata_i[{addr_i, 3'b000} +: 8];
    halfLane   = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      SIZE_WORD: begin
        be_o       = 4'b1111;
        misalign_o = (addr_i != 2'b00);
      end
      SIZE_HALF: begin
        be_o       = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{sign_i & halfLane[15]}}, halfLane};
        misalign_o = addr_i[0];
      end
      SIZE_BYTE: begin
        be_o    = 4'b0001 << addr_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & byteLane[7]}}, byteLane};
      end
      default: begin
        be_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: validates a request, issues one bus access,
// stalls until ack or timeout, and reports completion or an exception.
module mem_access_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              busWe_q, busWe_d;
  logic [31:0]       busAddr_q, busAddr_d;
  logic [3:0]        busBe_q, busBe_d;
  logic [31:0]       busWdata_q, busWdata_d;
  logic [1:0]        size_q, size_d;
  logic [1:0]        addrLo_q, addrLo_d;
  logic              sign_q, sign_d;

  logic              inIdle;
  logic [1:0]        alSize;
  logic [1:0]        alAddr;
  logic              alSign;
  logic [3:0]        alBe;
  logic [31:0]       alWdata;
  logic [31:0]       alRdata;
  logic              alMisalign;
  logic              reqIllegal;

  // One aligner serves both directions: live request fields while idle,
  // the registered copies while the load is outstanding.
  assign inIdle = (state_q == ST_IDLE);
  assign alSize = inIdle ? req_size       : size_q;
  assign alAddr = inIdle ? req_addr[1:0]  : addrLo_q;
  assign alSign = inIdle ? req_sign       : sign_q;

  mem_lane_align u_align (
    .size_i     (alSize),
    .addr_i     (alAddr),
    .sign_i     (alSign),
    .wdata_i    (req_wdata),
    .rdata_i    (bus_rdata),
    .be_o       (alBe),
    .wdata_o    (alWdata),
    .rdata_o    (alRdata),
    .misalign_o (alMisalign)
  );

  assign reqIllegal = (req_size == SIZE_RSV) || alMisalign;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    rdata_d    = rdata_q;
    busWe_d    = busWe_q;
    busAddr_d  = busAddr_q;
    busBe_d    = busBe_q;
    busWdata_d = busWdata_q;
    size_d     = size_q;
    addrLo_d   = addrLo_q;
    sign_d     = sign_q;
    stall      = 1'b0;
    rsp_valid  = 1'b0;
    exc_valid  = 1'b0;
    exc_code   = 5'd0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          if (reqIllegal) begin
            exc_valid = 1'b1;
            exc_code  = addr_exc_code(req_size, req_we);
          end else begin
            stall      = 1'b1;
            state_d    = ST_BUS;
            cnt_d      = '0;
            err_d      = 1'b0;
            busWe_d    = req_we;
            busAddr_d  = {req_addr[31:2], 2'b00};
            busBe_d    = req_we ? alBe : 4'b1111;
            busWdata_d = alWdata;
            size_d     = req_size;
            addrLo_d   = req_addr[1:0];
            sign_d     = req_sign;
          end
        end
      end
      // Flush is deliberately not looked at here: an issued access must finish.
      ST_BUS: begin
        stall = 1'b1;
        if (bus_ack) begin
          if (!busWe_q) begin
            rdata_d = alRdata;
          end
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (err_q) begin
          exc_valid = 1'b1;
          exc_code  = EXC_DBE;
        end
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
      busWe_q    <= 1'b0;
      busAddr_q  <= '0;
      busBe_q    <= '0;
      busWdata_q <= '0;
      size_q     <= '0;
      addrLo_q   <= '0;
      sign_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      busWe_q    <= busWe_d;
      busAddr_q  <= busAddr_d;
      busBe_q    <= busBe_d;
      busWdata_q <= busWdata_d;
      size_q     <= size_d;
      addrLo_q   <= addrLo_d;
      sign_q     <= sign_d;
    end
  end

  assign bus_req   = (state_q == ST_BUS);
  assign bus_we    = busWe_q;
  assign bus_addr  = busAddr_q;
  assign bus_be    = busBe_q;
  assign bus_wdata = busWdata_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios followed by
// randomized accesses compared against a byte-lane arithmetic model.
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        reqValid = 1'b0;
  logic        reqWe = 1'b0;
  logic [1:0]  reqSize = 2'b00;
  logic        reqSign = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic        flush = 1'b0;
  logic        stall;
  logic        rspValid;
  logic [31:0] rspRdata;
  logic        excValid;
  logic [4:0]  excCode;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busAck = 1'b0;
  logic [31:0] busRdata = '0;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] expRdata = '0;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk       (clk),
    .reset_n   (resetN),
    .req_valid (reqValid),
    .req_we    (reqWe),
    .req_size  (reqSize),
    .req_sign  (reqSign),
    .req_addr  (reqAddr),
    .req_wdata (reqWdata),
    .flush     (flush),
    .stall     (stall),
    .rsp_valid (rspValid),
    .rsp_rdata (rspRdata),
    .exc_valid (excValid),
    .exc_code  (excCode),
    .bus_req   (busReq),
    .bus_we    (busWe),
    .bus_addr  (busAddr),
    .bus_be    (busBe),
    .bus_wdata (busWdata),
    .bus_ack   (busAck),
    .bus_rdata (busRdata)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic bit modelLegal(input logic [1:0] size, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    case (size)
      2'b00:   return off == 0;
      2'b10:   return (off % 2) == 0;
      2'b01:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelExcCode(input logic [1:0] size, input logic we);
    if (size == 2'b11) return 32'd10;
    return we ? 32'd5 : 32'd4;
  endfunction

  function automatic logic [31:0] modelBe(input logic [1:0] size, input logic we, input logic [31:0] addr);
    int off;
    off = int'(addr % 4);
    if (!we) return 32'hF;
    case (size)
      2'b10:   return 32'(3 << off);
      2'b01:   return 32'(1 << off);
      default: return 32'hF;
    endcase
  endfunction

  function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] wdata);
    logic [31:0] b;
    logic [31:0] h;
    b = wdata & 32'hFF;
    h = wdata & 32'hFFFF;
    case (size)
      2'b01:   return b * 32'h01010101;
      2'b10:   return h * 32'h00010001;
      default: return wdata;
    endcase
  endfunction

  function automatic logic [31:0] modelRdata(input logic [1:0] size, input logic sign,
                                             input logic [31:0] addr, input logic [31:0] rdata);
    int off;
    logic [31:0] v;
    off = int'(addr % 4);
    case (size)
      2'b01: begin
        v = (rdata >> (8 * off)) & 32'hFF;
        if (sign && v >= 32'h80) v = v | 32'hFFFFFF00;
      end
      2'b10: begin
        v = (rdata >> (8 * off)) & 32'hFFFF;
        if (sign && v >= 32'h8000) v = v | 32'hFFFF0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  // ackDelay < 0 means the bus never answers; flushAt is the bus cycle where flush rises.
  task automatic applyStimulus(input logic we, input logic [1:0] size, input logic sign,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int ackDelay, input int flushAt);
    int busCycles;
    int expCycles;
    bit done;
    bit timedOut;
    reqValid = 1'b1;
    reqWe    = we;
    reqSize  = size;
    reqSign  = sign;
    reqAddr  = addr;
    reqWdata = wdata;
    flush    = 1'b0;
    busAck   = 1'b0;
    #1;
    if (!modelLegal(size, addr)) begin
      checkOutput("excValidIllegal", excValid, 1);
      checkOutput("excCodeIllegal", excCode, modelExcCode(size, we));
      checkOutput("stallIllegal", stall, 0);
      nextCycle();
      reqValid = 1'b0;
      #1;
      checkOutput("busReqIllegal", busReq, 0);
      checkOutput("stallAfterIllegal", stall, 0);
      return;
    end
    checkOutput("stallAccept", stall, 1);
    checkOutput("excAccept", excValid, 0);
    checkOutput("busReqAccept", busReq, 0);
    busCycles = 0;
    done = 1'b0;
    for (int k = 0; k < TIMEOUT + 4 && !done; k++) begin
      nextCycle();
      busAck = 1'b0;
      if (busReq !== 1'b1) begin
        done = 1'b1;
      end else begin
        busCycles++;
        checkOutput("stallBus", stall, 1);
        checkOutput("busAddr", busAddr, addr & 32'hFFFFFFFC);
        checkOutput("busBe", busBe, modelBe(size, we, addr));
        checkOutput("busWe", busWe, we);
        if (we) checkOutput("busWdata", busWdata, modelWdata(size, wdata));
        if (k == flushAt) flush = 1'b1;
        if (k == ackDelay) begin
          busAck   = 1'b1;
          busRdata = rdata;
        end
      end
    end
    busAck = 1'b0;
    flush  = 1'b0;
    checkOutput("busBound", done, 1);
    timedOut  = (ackDelay < 0) || (ackDelay >= TIMEOUT);
    expCycles = timedOut ? TIMEOUT : ackDelay + 1;
    checkOutput("busCycles", busCycles, expCycles);
    #1;
    checkOutput("rspValidDone", rspValid, 1);
    checkOutput("stallDone", stall, 0);
    checkOutput("excValidDone", excValid, timedOut);
    if (timedOut) checkOutput("excCodeDbe", excCode, 7);
    if (!we) begin
      if (!timedOut) expRdata = modelRdata(size, sign, addr, rdata);
      checkOutput("rspRdata", rspRdata, expRdata);
    end
    nextCycle();
    reqValid = 1'b0;
    #1;
    checkOutput("rspValidAfter", rspValid, 0);
    checkOutput("busReqAfter", busReq, 0);
    checkOutput("stallAfter", stall, 0);
  endtask

  initial begin
    logic        rWe;
    logic [1:0]  rSize;
    logic        rSign;
    logic [31:0] rAddr;
    int          rAck;

    #1;
    checkOutput("resetBusReq", busReq, 0);
    checkOutput("resetStall", stall, 0);
    checkOutput("resetRspValid", rspValid, 0);
    checkOutput("resetExcValid", excValid, 0);
    checkOutput("resetRspRdata", rspRdata, 0);
    checkOutput("resetBusAddr", busAddr, 0);
    checkOutput("resetBusBe", busBe, 0);
    nextCycle();
    resetN = 1'b1;
    nextCycle();

    $display("[TB] store byte with two bus cycles");
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 1, -1);

    $display("[TB] half loads, signed and unsigned");
    applyStimulus(1'b0, 2'b10, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, -1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_1234, 0, -1);

    $display("[TB] address errors");
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0006, 32'h1234_5678, 32'h0, 0, -1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 32'h0, 0, -1);
    applyStimulus(1'b1, 2'b11, 1'b0, 32'h0000_0004, 32'h0, 32'h0, 0, -1);

    $display("[TB] bus timeout");
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_3000, 32'h0, 32'hDEAD_BEEF, -1, -1);

    $display("[TB] flush in idle and during bus");
    reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'b00; reqAddr = 32'h0000_0100; flush = 1'b1;
    #1;
    checkOutput("flushIdleStall", stall, 0);
    checkOutput("flushIdleExc", excValid, 0);
    nextCycle();
    checkOutput("flushIdleBusReq", busReq, 0);
    reqValid = 1'b0; flush = 1'b0;
    nextCycle();
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 5, 3);

    $display("[TB] stray ack in idle");
    busAck = 1'b1; busRdata = 32'h1111_1111;
    nextCycle();
    busAck = 1'b0;
    #1;
    checkOutput("strayAckBusReq", busReq, 0);
    checkOutput("strayAckRspValid", rspValid, 0);
    checkOutput("strayAckRdata", rspRdata, expRdata);

    $display("[TB] reset during bus access");
    reqValid = 1'b1; reqWe = 1'b0; reqSize = 2'b00; reqAddr = 32'h0000_0040;
    nextCycle();
    nextCycle();
    checkOutput("preResetBusReq", busReq, 1);
    resetN = 1'b0; reqValid = 1'b0;
    #1;
    checkOutput("midResetBusReq", busReq, 0);
    checkOutput("midResetStall", stall, 0);
    checkOutput("midResetRspValid", rspValid, 0);
    checkOutput("midResetBusBe", busBe, 0);
    checkOutput("midResetRdata", rspRdata, 0);
    expRdata = '0;
    nextCycle();
    resetN = 1'b1;
    nextCycle();
    checkOutput("postResetBusReq", busReq, 0);
    applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0080, 32'h0, 32'h0BAD_C0DE, 2, -1);

    $display("[TB] randomized accesses");
    for (int n = 0; n < 40; n++) begin
      rWe   = 1'($urandom_range(0, 1));
      rSize = 2'($urandom_range(0, 3));
      rSign = 1'($urandom_range(0, 1));
      rAddr = $urandom;
      rAck  = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 4));
      applyStimulus(rWe, rSize, rSign, rAddr, $urandom, $urandom, rAck, int'($urandom_range(0, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences MEM-stage load/store requests onto the single-port data memory/bridge bus. It performs alignment and size checks, generates byte enables and lane-shifted write data, and extracts and extends load data. It stalls the pipeline until the bus acknowledges. It raises address-error and bus-timeout exceptions to the CP0/exception logic.

Parameters:
TIMEOUT, 16, bus cycles waited for bus_ack before a bus error is raised (≥2).
CNT_W, 5, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  MEM stage holds a load/store
req_we  in  1  1=store, 0=load
req_size  in  2  00=word, 10=half, 01=byte, 11=reserved
req_sign  in  1  load sign-extend (lb/lh) vs zero-extend (lbu/lhu)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-justified
flush  in  1  exception/interrupt kill of the MEM instruction
stall  out  1  freeze pipeline
rsp_valid  out  1  access complete this cycle
rsp_rdata  out  32  extended load data
exc_valid  out  1  exception this cycle
exc_code  out  5  4=AdEL, 5=AdES, 7=DBE, 10=RI
bus_req  out  1  bus request
bus_we  out  1  bus write
bus_addr  out  32  word address, [1:0]=00
bus_be  out  4  byte lanes
bus_wdata  out  32  lane-placed write data
bus_ack  in  1  bus completion (one-cycle pulse)
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- FSM states: IDLE, BUS, DONE. Reset is asynchronous: state=IDLE, counter=0, and all registered outputs go to 0 (bus_*, rsp_rdata, exc from DONE). Reset mid-BUS drops bus_req immediately.
- IDLE with req_valid=0, or flush=1: stall=0, no action.
- IDLE with req_valid=1, flush=0, and an illegal request: the access is illegal if req_size=11, or word with addr[1:0]≠0, or half with addr[0]=1.
  - Combinationally assert exc_valid=1 with exc_code=10 for reserved size; otherwise 5 for a store, 4 for a load.
  - stall=0, no bus access, stay in IDLE.
- IDLE with a legal request: stall=1 combinationally. The next edge registers bus_* (addr with [1:0] forced to 00) and moves to BUS with counter=0.
- Byte enables (req_size, addr[1:0]):
  - word → 1111.
  - half → 0011 for addr[1]=0, 1100 for addr[1]=1.
  - byte → one-hot 0001/0010/0100/1000 by addr[1:0].
  - bus_be=1111 for loads too.
- Write data: byte is replicated ×4, half is replicated ×2, word is passed unchanged.
- BUS: bus_req=1 and stall=1; bus_* held stable.
  - On bus_ack: latch the extracted load data and go to DONE.
  - Otherwise increment the counter. When counter reaches TIMEOUT-1 without ack, go to DONE with the bus-error flag set.
  - flush during BUS is ignored; an issued access always completes.
- DONE (one cycle): bus_req=0, stall=0, rsp_valid=1. If the bus-error flag is set, exc_valid=1 and exc_code=7, and rsp_rdata is unchanged. DONE always returns to IDLE, and req_valid in DONE is ignored.
- Load extraction: byte lane selected by addr[1:0], half lane by addr[1]. Sign- or zero-extend to 32 per req_sign; word is passed unchanged. Size and address are taken from the registered copies.
- A bus_ack outside BUS is ignored.
- Minimum latency: request accepted at T, bus_req high at T+1, ack at T+1 → DONE at T+2. stall is high during T and T+1.

Decomposition:
- Package cpu_mem_pkg holds:
  - SIZE_WORD/SIZE_HALF/SIZE_BYTE/SIZE_RSV encodings.
  - EXC_ADEL/EXC_ADES/EXC_DBE/EXC_RI codes.
  - The state enum.
- Sub-module mem_lane_align (combinational), shared by the store and load paths:
  - Inputs: size, addr[1:0], sign, wdata, rdata.
  - Outputs: be, lane wdata, extended rdata, misalign flag.

Test Plan:
- sb, addr=0x0000_1003, wdata=0x0000_00AB, ack after 2 cycles → bus_be=1000, bus_wdata=0xABABABAB, bus_addr=0x0000_1000; stall high 3 cycles, then rsp_valid=1 for 1 cycle.
- lh signed, addr=0x0000_2002, bus_rdata=0x8001_1234 → rsp_rdata=0xFFFF8001. Same access with lhu → 0x0000_8001.
- sw to addr=0x0000_0006 → exc_valid=1, exc_code=5 in the same cycle; bus_req never asserts; stall=0. A half load to addr 0x1 → exc_code=4.
- Load with no bus_ack, TIMEOUT=16 → bus_req high exactly 16 cycles, then DONE with exc_code=7; state returns to IDLE.
- Legal request with flush=1 in IDLE → no bus_req, no exc. Assert flush 3 cycles into BUS → access still completes on ack.
- reset_n pulsed low mid-BUS → bus_req, stall, and rsp_valid go to 0 asynchronously; after release, state is IDLE and a fresh lw works.
